// File: rtl/hasher_mem_responder.sv
// hasher_mem_responder: header/result word memory, minimum-hash tracker and start/done handshake for the SHA-256 nonce hasher
module hasher_mem_responder #(
  parameter int DEPTH      = 64,
  parameter int OUT_BASE   = 32,
  parameter int NUM_NONCES = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_we,
  input  logic [15:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  input  logic        go,
  input  logic [31:0] target,
  output logic        start,
  input  logic        done,
  input  logic [15:0] mem_addr,
  input  logic        mem_we,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        busy,
  output logic        result_valid,
  output logic        hit,
  output logic [31:0] best_hash,
  output logic [15:0] best_nonce,
  output logic        err_timeout
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] DEP = 16'(DEPTH);
  localparam logic [15:0] OUT_LO = 16'(OUT_BASE);
  localparam logic [15:0] OUT_HI = 16'(OUT_BASE + NUM_NONCES);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, START, RUN, REPORT} state_t;
  state_t state, state_d;
  logic [31:0] ram [DEPTH];
  logic [31:0] target_q, cur_hash, hash_d, cnt, wr_data;
  logic [15:0] cur_nonce, nonce_d;
  logic [AW-1:0] wr_addr;
  logic go_acc, hw_acc, better, timed_out, to_report, wr_en;
  assign start = state == START;
  assign busy = state != IDLE;
  assign result_valid = state == REPORT;
  always_comb begin
    go_acc = state == IDLE && go;
    hw_acc = (state == START || state == RUN) && mem_we;
    better = hw_acc && mem_addr >= OUT_LO && mem_addr < OUT_HI && mem_write_data < cur_hash;
    hash_d = better ? mem_write_data : cur_hash;
    nonce_d = better ? mem_addr - OUT_LO : cur_nonce;
    timed_out = state == RUN && !done && cnt == TO_LAST;
    to_report = state == RUN && (done || timed_out);
    state_d = state == IDLE ? (go ? START : IDLE) :
              state == START ? RUN :
              state == RUN ? (to_report ? REPORT : RUN) : IDLE;
    // host owns the write port in IDLE, the hasher owns it while busy
    wr_en = state == IDLE ? host_we && host_addr < DEP : hw_acc && mem_addr < DEP;
    wr_addr = state == IDLE ? host_addr[AW-1:0] : mem_addr[AW-1:0];
    wr_data = state == IDLE ? host_wdata : mem_write_data;
  end
  always_ff @(posedge clk)
    if (wr_en) ram[wr_addr] <= wr_data;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      target_q <= '0;
      cur_hash <= '1;
      cur_nonce <= '0;
      cnt <= '0;
      hit <= 1'b0;
      best_hash <= '0;
      best_nonce <= '0;
      err_timeout <= 1'b0;
      mem_read_data <= '0;
      host_rdata <= '0;
    end else begin
      state <= state_d;
      mem_read_data <= mem_addr < DEP ? ram[mem_addr[AW-1:0]] : '0;
      host_rdata <= host_addr < DEP ? ram[host_addr[AW-1:0]] : '0;
      if (go_acc) begin
        target_q <= target;
        cur_hash <= '1;
        cur_nonce <= '0;
        cnt <= '0;
        hit <= 1'b0;
        best_hash <= '0;
        best_nonce <= '0;
        err_timeout <= 1'b0;
      end else begin
        cur_hash <= hash_d;
        cur_nonce <= nonce_d;
        if (state == RUN && cnt != '1) cnt <= cnt + 32'd1;
        // results include a write landing in the same cycle as done
        if (to_report) begin
          best_hash <= hash_d;
          best_nonce <= nonce_d;
          hit <= hash_d < target_q;
        end
        if (timed_out) err_timeout <= 1'b1;
      end
    end
endmodule
